// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider.
// Ratio updates land only on period boundaries so o_clk never glitches.
module clk_div_prog #(
    parameter int WIDTH         = 8,
    parameter int DEFAULT_RATIO = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_ratio,
    input  logic             i_ratio_vld,
    output logic             o_ratio_rdy,
    output logic [WIDTH-1:0] o_ratio_cur,
    output logic             o_cfg_err,
    output logic             o_clk,
    output logic             o_tick
);

    localparam logic [WIDTH-1:0] DEF_N = WIDTH'(DEFAULT_RATIO);
    localparam logic [WIDTH-1:0] MIN_N = WIDTH'(2);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] pend;
    logic             pend_vld;
    logic             stopped;

    logic             accept;
    logic [WIDTH-1:0] clamp;
    logic             wrap;
    logic             bnd;
    logic [WIDTH-1:0] ratio_nxt;
    logic [WIDTH-1:0] cnt_nxt;
    logic [WIDTH:0]   high_nxt;
    logic             run_nxt;
    logic             clk_nxt;
    logic             tick_nxt;

    assign o_ratio_rdy = ~pend_vld;

    // Next-state: boundary detection, ratio swap and phase of the next cycle
    always_comb begin
        accept    = i_ratio_vld && !pend_vld;
        clamp     = (i_ratio < MIN_N) ? MIN_N : i_ratio;
        wrap      = !stopped && (cnt == o_ratio_cur - WIDTH'(1));
        bnd       = wrap || (stopped && (i_en || pend_vld));
        ratio_nxt = (bnd && pend_vld) ? pend : o_ratio_cur;
        high_nxt  = ({1'b0, ratio_nxt} + (WIDTH+1)'(1)) >> 1;
        run_nxt   = !stopped;
        cnt_nxt   = stopped ? cnt : cnt + WIDTH'(1);
        if (bnd) begin
            run_nxt = i_en;
            cnt_nxt = i_en ? '0 : ratio_nxt - WIDTH'(1);
        end
        clk_nxt  = run_nxt && ({1'b0, cnt_nxt} < high_nxt);
        tick_nxt = bnd && i_en;
    end

    // Counter, run state and registered clock/tick outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt         <= DEF_N - WIDTH'(1);
            o_ratio_cur <= DEF_N;
            stopped     <= 1'b1;
            o_clk       <= 1'b0;
            o_tick      <= 1'b0;
        end else begin
            cnt         <= cnt_nxt;
            o_ratio_cur <= ratio_nxt;
            stopped     <= !run_nxt;
            o_clk       <= clk_nxt;
            o_tick      <= tick_nxt;
        end
    end

    // Single-entry pending slot for ratio requests, with clamp error pulse
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pend      <= DEF_N;
            pend_vld  <= 1'b0;
            o_cfg_err <= 1'b0;
        end else begin
            o_cfg_err <= accept && (i_ratio < MIN_N);
            if (accept) begin
                pend     <= clamp;
                pend_vld <= 1'b1;
            end else if (bnd) begin
                pend_vld <= 1'b0;
            end
        end
    end

endmodule
